// File: rtl/spi_pkg.sv
// Shared types and constants for the write-only SPI initiator.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  // Register map of the on-chip peripheral
  localparam logic [ADDR_W-1:0] REG_OUT_7_0  = 7'd0;
  localparam logic [ADDR_W-1:0] REG_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] REG_PWM_7_0  = 7'd2;
  localparam logic [ADDR_W-1:0] REG_PWM_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY = 7'd4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  // Frame layout, MSB first on the wire: command, address, data
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic              cmd,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {cmd, addr, data};
  endfunction

endpackage

// File: rtl/spi_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
// Loading N-1 makes tc appear in the Nth cycle after the load edge.
module spi_timer
  import spi_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt_r;

  // Count down to zero and park there until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign tc = (cnt_r == '0);

endmodule

// File: rtl/spi_controller.sv
// Write-only SPI mode-0 initiator: one 16-bit frame per accepted request.
// All pins and status flags come straight from flops; next values are
// computed together with the next state so they change on the same edge.
module spi_controller
  import spi_pkg::*;
#(
  parameter int   CLK_DIV   = 4,
  parameter int   CS_SETUP  = 4,
  parameter int   CS_HOLD   = 4,
  parameter int   CS_GAP    = 8,
  parameter int   MAX_ADDR  = 4,
  parameter logic WRITE_CMD = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              SCLK,
  output logic              nCS,
  output logic              COPI
);

  // One timer serves every delay, so size it for the longest one
  localparam int M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2      = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_DLY = (M1 > M2) ? M1 : M2;
  localparam int TW      = $clog2(MAX_DLY) + 1;

  localparam logic [TW-1:0]     DIV_LD   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]     SETUP_LD = TW'(CS_SETUP - 1);
  localparam logic [TW-1:0]     HOLD_LD  = TW'(CS_HOLD - 1);
  localparam logic [TW-1:0]     GAP_LD   = TW'(CS_GAP - 1);
  localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);

  state_e             state_r, state_n;
  logic [FRAME_W-1:0] shreg_r, shreg_n;
  logic [4:0]         bit_cnt_r, bit_cnt_n;
  logic               sclk_r, sclk_n;
  logic               ncs_r, ncs_n;
  logic               copi_r, copi_n;
  logic               done_r, done_n;
  logic               err_r, err_n;
  logic               busy_r;
  logic               ready_r;
  logic [FRAME_W-1:0] frame_s;
  logic               tmr_load_s;
  logic [TW-1:0]      tmr_val_s;
  logic               tmr_tc_s;

  spi_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .tc       (tmr_tc_s)
  );

  // Next-state and next-output decode
  always_comb begin
    state_n    = state_r;
    shreg_n    = shreg_r;
    bit_cnt_n  = bit_cnt_r;
    sclk_n     = sclk_r;
    ncs_n      = ncs_r;
    copi_n     = copi_r;
    done_n     = 1'b0;
    err_n      = 1'b0;
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    frame_s    = build_frame(WRITE_CMD, req_addr, req_data);
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          if (req_addr > MAX_A) begin
            // Accepted but rejected: flag it and stay put
            err_n = 1'b1;
          end else begin
            shreg_n    = frame_s;
            copi_n     = frame_s[FRAME_W-1];
            ncs_n      = 1'b0;
            sclk_n     = 1'b0;
            state_n    = SETUP;
            tmr_load_s = 1'b1;
            tmr_val_s  = SETUP_LD;
          end
        end else begin
          state_n = IDLE;
        end
      end
      SETUP: begin
        if (tmr_tc_s) begin
          state_n    = SHIFT;
          bit_cnt_n  = 5'd0;
          tmr_load_s = 1'b1;
          tmr_val_s  = DIV_LD;
        end else begin
          state_n = SETUP;
        end
      end
      SHIFT: begin
        if (tmr_tc_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = DIV_LD;
          if (!sclk_r) begin
            // End of low phase: rise, data already stable
            sclk_n = 1'b1;
          end else if (bit_cnt_r == 5'd15) begin
            // Last falling edge; COPI keeps bit 0 through HOLD
            sclk_n    = 1'b0;
            state_n   = HOLD;
            tmr_val_s = HOLD_LD;
          end else begin
            // Falling edge is the only place data moves
            sclk_n    = 1'b0;
            shreg_n   = {shreg_r[FRAME_W-2:0], 1'b0};
            copi_n    = shreg_r[FRAME_W-2];
            bit_cnt_n = bit_cnt_r + 5'd1;
          end
        end else begin
          state_n = SHIFT;
        end
      end
      HOLD: begin
        if (tmr_tc_s) begin
          ncs_n      = 1'b1;
          copi_n     = 1'b0;
          state_n    = GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
        end else begin
          state_n = HOLD;
        end
      end
      GAP: begin
        if (tmr_tc_s) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          state_n = GAP;
        end
      end
      default: begin
        state_n = IDLE;
        sclk_n  = 1'b0;
        ncs_n   = 1'b1;
        copi_n  = 1'b0;
      end
    endcase
  end

  // State, shift register and all output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      shreg_r   <= '0;
      bit_cnt_r <= 5'd0;
      sclk_r    <= 1'b0;
      ncs_r     <= 1'b1;
      copi_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
    end else begin
      state_r   <= state_n;
      shreg_r   <= shreg_n;
      bit_cnt_r <= bit_cnt_n;
      sclk_r    <= sclk_n;
      ncs_r     <= ncs_n;
      copi_r    <= copi_n;
      done_r    <= done_n;
      err_r     <= err_n;
      busy_r    <= (state_n != IDLE);
      ready_r   <= (state_n == IDLE);
    end
  end

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign SCLK      = sclk_r;
  assign nCS       = ncs_r;
  assign COPI      = copi_r;

endmodule

// File: tb/tb_spi_controller.sv
// Scoreboard bench for spi_controller with a behavioural SPI receiver.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 4;
  localparam int CS_HOLD  = 4;
  localparam int CS_GAP   = 8;
  localparam int MAX_ADDR = 4;
  localparam int LAT      = CS_SETUP + 32*CLK_DIV + CS_HOLD + CS_GAP + 1;
  localparam int CS_LOW   = CS_SETUP + 32*CLK_DIV + CS_HOLD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       req_ready, busy, done, err, SCLK, nCS, COPI;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] exp_q[$];
  int          acc_q[$];

  logic        prev_sclk = 1'b0, prev_ncs = 1'b1, prev_copi = 1'b0;
  logic [15:0] rx_sh = 16'h0000;
  int          rx_cnt = 0, low_cnt = 0, hi_cnt = 0, last_gap = 0, done_cyc = 0;
  int          acc_cyc_last = 0;
  logic [7:0]  reg_model [0:4];

  spi_controller #(
    .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
    .CS_GAP(CS_GAP), .MAX_ADDR(MAX_ADDR), .WRITE_CMD(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .busy(busy), .done(done),
    .err(err), .SCLK(SCLK), .nCS(nCS), .COPI(COPI)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Receiver model, protocol checker and scoreboard consumer
  always @(negedge clk) begin
    logic [15:0] exp_f;
    if (!rst_n) begin
      rx_cnt = 0; rx_sh = 16'h0000; low_cnt = 0; hi_cnt = 0;
      exp_q.delete(); acc_q.delete();
    end else begin
      if (COPI !== prev_copi) check_val("copi_change_sclk_low", {31'd0, SCLK}, 32'd0);
      if (SCLK !== prev_sclk) check_val("sclk_edge_ncs_low", {31'd0, nCS}, 32'd0);
      if (SCLK && !prev_sclk) begin
        rx_sh = {rx_sh[14:0], COPI};
        rx_cnt++;
      end
      if (!nCS && prev_ncs) begin
        last_gap = hi_cnt; low_cnt = 0; rx_cnt = 0;
      end
      if (nCS && !prev_ncs) begin
        check_val("rx_bits", rx_cnt, 16);
        check_val("ncs_low_cycles", low_cnt, CS_LOW);
        check_val("frame_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        exp_f = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check_val("frame", {16'd0, rx_sh}, {16'd0, exp_f});
        if (rx_sh[15] == 1'b0 && rx_sh[14:8] <= 7'd4) reg_model[rx_sh[10:8]] = rx_sh[7:0];
        hi_cnt = 0;
      end
      if (!nCS) low_cnt++;
      if (nCS && !done) hi_cnt++;
      if (done || err) check_val("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (done) begin
        check_val("done_has_accept", {31'd0, acc_q.size() > 0}, 32'd1);
        if (acc_q.size() > 0) check_val("done_latency", cyc - acc_q.pop_front() + 1, LAT);
        done_cyc = cyc;
      end
    end
    prev_sclk = SCLK; prev_ncs = nCS; prev_copi = COPI;
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_req(input logic [6:0] a, input logic [7:0] d, input bit keep_valid);
    bit ok;
    wait_ready(ok);
    check_val("ready_wait", {31'd0, ok}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_data = d;
    if (a <= 7'(MAX_ADDR)) exp_q.push_back(build_frame(1'b0, a, d));
    @(posedge clk);
    #1;
    if (a <= 7'(MAX_ADDR)) acc_q.push_back(cyc);
    acc_cyc_last = cyc;
    if (!keep_valid) req_valid = 1'b0;
  endtask

  initial begin
    bit ok;
    int bad;
    int c0;
    for (int i = 0; i < 5; i++) reg_model[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 7'd0; req_data = 8'd0;
    repeat (3) @(negedge clk);
    check_val("reset_state", {25'd0, SCLK, nCS, COPI, done, err, busy, req_ready}, 32'b0100001);
    rst_n = 1'b1;

    // Basic frame to register 0
    do_req(7'd0, 8'hA5, 1'b0);
    @(negedge clk);
    check_val("busy_after_accept", {30'd0, busy, req_ready}, 32'b10);
    wait_done(ok);
    check_val("done_seen_1", {31'd0, ok}, 32'd1);
    check_val("reg0_a5", {24'd0, reg_model[0]}, 32'hA5);

    // Duty register; neighbour must not move
    do_req(7'd4, 8'h80, 1'b0);
    wait_done(ok);
    check_val("done_seen_2", {31'd0, ok}, 32'd1);
    check_val("reg4_duty", {24'd0, reg_model[4]}, 32'h80);
    check_val("reg3_untouched", {24'd0, reg_model[3]}, 32'h00);

    // Out-of-range address is rejected
    do_req(7'd5, 8'h11, 1'b0);
    @(negedge clk);
    check_val("err_pulse", {27'd0, err, req_ready, nCS, SCLK, busy}, 32'b11100);
    @(negedge clk);
    check_val("err_one_cycle", {31'd0, err}, 32'd0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || !nCS || SCLK) bad++;
    end
    check_val("illegal_quiet", bad, 0);

    // Back-to-back frames with req_valid held high
    do_req(7'd1, 8'hFF, 1'b1);
    req_addr = 7'd1; req_data = 8'hFF;
    do_req(7'd2, 8'h0F, 1'b0);
    check_val("b2b_accept_in_done", acc_cyc_last, done_cyc + 1);
    wait_done(ok);
    check_val("done_seen_b2b", {31'd0, ok}, 32'd1);
    check_val("b2b_gap", last_gap, CS_GAP);
    check_val("reg1_ff", {24'd0, reg_model[1]}, 32'hFF);
    check_val("reg2_0f", {24'd0, reg_model[2]}, 32'h0F);

    // Asynchronous reset in the middle of frame bit 7
    do_req(7'd0, 8'hFF, 1'b0);
    c0 = cyc;
    repeat (74) @(negedge clk);
    check_val("pre_reset_bit7", {29'd0, SCLK, COPI, nCS}, 32'b110);
    check_val("pre_reset_cycle", cyc - c0, 73);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset", {25'd0, SCLK, nCS, COPI, done, err, busy, req_ready}, 32'b0100001);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_req(7'd0, 8'h3C, 1'b0);
    wait_done(ok);
    check_val("done_after_reset", {31'd0, ok}, 32'd1);
    check_val("reg0_3c", {24'd0, reg_model[0]}, 32'h3C);
    check_val("scoreboard_empty", exp_q.size(), 0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
